// File: rtl/matching_store.sv
// Multi-entry matching memory: parks operand tokens and fires an L/R pair
// as one packet when an arriving token meets its stored partner.
module matching_store #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 18,
    parameter int DATA_W = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              cp,
    input  logic              mr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_lr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_l_data,
    output logic [DATA_W-1:0] out_r_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_lr;
    logic [TAG_W-1:0]  ent_tag  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              out_free;
    logic              accept;
    logic              fire;
    logic              park;
    logic [DATA_W-1:0] stored_data;

    // Scanning from the top down lets the lowest matching/free index win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        hit      = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_tag[i] == in_tag) && (ent_lr[i] != in_lr)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!ent_valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign out_free    = !out_valid || out_ready;
    assign in_ready    = mr && out_free && (hit || !full) && !flush;
    assign accept      = in_valid && in_ready;
    assign fire        = accept && hit;
    assign park        = accept && !hit;
    assign stored_data = ent_data[hit_idx];

    // Occupancy bookkeeping: flush dominates any token offered in the same cycle.
    always_ff @(posedge cp or negedge mr) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!mr) begin
            ent_valid <= '0;
            count     <= '0;
        end else if (flush) begin
            ent_valid <= '0;
            count     <= '0;
        end else if (fire) begin
            ent_valid[hit_idx] <= 1'b0;
            count              <= count - CNT_W'(1);
        end else if (park) begin
            ent_valid[free_idx] <= 1'b1;
            count               <= count + CNT_W'(1);
        end
    end

    // NOTE: entry payload has no reset; the valid bits alone say whether it is meaningful.
    always_ff @(posedge cp) begin
        if (park) begin
            ent_tag[free_idx]  <= in_tag;
            ent_lr[free_idx]   <= in_lr;
            ent_data[free_idx] <= in_data;
        end
    end

    // A fire and a drain in the same cycle reload the register with no bubble.
    always_ff @(posedge cp or negedge mr) begin
        if (!mr) begin
            out_valid  <= 1'b0;
            out_tag    <= '0;
            out_l_data <= '0;
            out_r_data <= '0;
        end else if (fire) begin
            out_valid  <= 1'b1;
            out_tag    <= in_tag;
            out_l_data <= in_lr ? stored_data : in_data;
            out_r_data <= in_lr ? in_data : stored_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matching_store.sv
// Self-checking bench for matching_store: directed scenarios plus a random
// run against a slot-array reference model.
module tb_matching_store;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 18;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              cp;
    logic              mr;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [TAG_W-1:0]  in_tag;
    logic              in_lr;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_l_data;
    logic [DATA_W-1:0] out_r_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    int errors = 0;
    int checks = 0;

    matching_store #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .cp(cp), .mr(mr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_lr(in_lr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_l_data(out_l_data), .out_r_data(out_r_data),
        .count(count), .full(full), .empty(empty)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    // Drives one cycle of stimulus; in_ready is sampled mid-cycle, outputs settle #1 after the edge.
    task automatic step(input logic v, input logic [TAG_W-1:0] tag, input logic lr,
                        input logic [DATA_W-1:0] d, input logic ordy, input logic fl,
                        output logic rdy);
        in_valid  = v;
        in_tag    = tag;
        in_lr     = lr;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge cp);
        rdy = in_ready;
        @(posedge cp);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        mr = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_tag = 18'h00A5; in_lr = 1'b0; in_data = 16'h1234;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_tag !== '0 || out_l_data !== '0 || out_r_data !== '0) begin errors++; $display("FAIL reset_out_fields: got %h %h %h want 0 0 0", out_tag, out_l_data, out_r_data); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b want 1 0", empty, full); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        @(negedge cp);
        mr = 1'b1;
        @(posedge cp);
        #1;
    endtask

    task automatic test_pair_fire();
        logic r;
        step(1'b1, 18'h00A5, 1'b0, 16'h1111, 1'b1, 1'b0, r);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL pair_park_ready: got %b want 1", r); end
        checks++; if (count !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL pair_park_state: got count=%0d ov=%b want 1 0", count, out_valid); end
        step(1'b1, 18'h00A5, 1'b1, 16'h2222, 1'b1, 1'b0, r);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL pair_fire_ready: got %b want 1", r); end
        checks++; if (out_valid !== 1'b1 || out_tag !== 18'h00A5) begin errors++; $display("FAIL pair_out: got ov=%b tag=%h want 1 00a5", out_valid, out_tag); end
        checks++; if (out_l_data !== 16'h1111 || out_r_data !== 16'h2222) begin errors++; $display("FAIL pair_data: got %h %h want 1111 2222", out_l_data, out_r_data); end
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL pair_count: got %0d empty=%b want 0 1", count, empty); end
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, r);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pair_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reverse();
        logic r;
        step(1'b1, 18'h00A5, 1'b1, 16'h3333, 1'b1, 1'b0, r);
        step(1'b1, 18'h00A5, 1'b0, 16'h4444, 1'b1, 1'b0, r);
        checks++; if (out_valid !== 1'b1 || out_l_data !== 16'h4444 || out_r_data !== 16'h3333) begin errors++; $display("FAIL reverse_data: got ov=%b %h %h want 1 4444 3333", out_valid, out_l_data, out_r_data); end
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, r);
    endtask

    task automatic test_same_side();
        logic r;
        step(1'b1, 18'h10, 1'b0, 16'd1, 1'b1, 1'b0, r);
        step(1'b1, 18'h10, 1'b0, 16'd2, 1'b1, 1'b0, r);
        checks++; if (count !== 4'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL same_side_park: got count=%0d ov=%b want 2 0", count, out_valid); end
        step(1'b1, 18'h10, 1'b1, 16'd9, 1'b1, 1'b0, r);
        checks++; if (out_valid !== 1'b1 || out_l_data !== 16'd1 || out_r_data !== 16'd9 || count !== 4'd1) begin errors++; $display("FAIL same_side_first: got ov=%b %h %h count=%0d want 1 0001 0009 1", out_valid, out_l_data, out_r_data, count); end
        step(1'b1, 18'h10, 1'b1, 16'hA, 1'b1, 1'b0, r);
        checks++; if (out_valid !== 1'b1 || out_l_data !== 16'd2 || out_r_data !== 16'hA || count !== 4'd0) begin errors++; $display("FAIL same_side_second: got ov=%b %h %h count=%0d want 1 0002 000a 0", out_valid, out_l_data, out_r_data, count); end
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, r);
    endtask

    task automatic test_full();
        logic r;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 18'h100 + TAG_W'(i), 1'b0, DATA_W'(i), 1'b1, 1'b0, r);
            checks++; if (r !== 1'b1) begin errors++; $display("FAIL full_park_ready[%0d]: got %b want 1", i, r); end
        end
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL full_flag: got full=%b count=%0d want 1 8", full, count); end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 18'h200, 1'b0, 16'h0BAD, 1'b1, 1'b0, r);
            checks++; if (r !== 1'b0 || count !== 4'd8) begin errors++; $display("FAIL full_stall[%0d]: got ready=%b count=%0d want 0 8", k, r, count); end
        end
        step(1'b1, 18'h103, 1'b1, 16'h0055, 1'b1, 1'b0, r);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL full_hit_ready: got %b want 1", r); end
        checks++; if (out_valid !== 1'b1 || out_tag !== 18'h103 || out_l_data !== 16'd3 || out_r_data !== 16'h0055) begin errors++; $display("FAIL full_hit_out: got ov=%b tag=%h %h %h want 1 00103 0003 0055", out_valid, out_tag, out_l_data, out_r_data); end
        checks++; if (full !== 1'b0 || count !== 4'd7) begin errors++; $display("FAIL full_drop: got full=%b count=%0d want 0 7", full, count); end
        step(1'b1, 18'h200, 1'b0, 16'h0BAD, 1'b1, 1'b0, r);
        checks++; if (r !== 1'b1 || full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL full_held_accept: got ready=%b full=%b count=%0d want 1 1 8", r, full, count); end
        step(1'b1, 18'h200, 1'b1, 16'h0C0D, 1'b1, 1'b0, r);
        checks++; if (out_valid !== 1'b1 || out_l_data !== 16'h0BAD || out_r_data !== 16'h0C0D) begin errors++; $display("FAIL full_held_fire: got ov=%b %h %h want 1 0bad 0c0d", out_valid, out_l_data, out_r_data); end
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, r);
        checks++; if (count !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL full_flush: got count=%0d empty=%b ov=%b want 0 1 0", count, empty, out_valid); end
    endtask

    task automatic test_backpressure();
        logic r;
        step(1'b1, 18'h55, 1'b0, 16'h000A, 1'b0, 1'b0, r);
        step(1'b1, 18'h66, 1'b0, 16'h000C, 1'b0, 1'b0, r);
        step(1'b1, 18'h55, 1'b1, 16'h000B, 1'b0, 1'b0, r);
        checks++; if (out_valid !== 1'b1 || out_tag !== 18'h55) begin errors++; $display("FAIL bp_first_fire: got ov=%b tag=%h want 1 00055", out_valid, out_tag); end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 18'h66, 1'b1, 16'h000D, 1'b0, 1'b0, r);
            checks++; if (r !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", k, r); end
            checks++; if (out_valid !== 1'b1 || out_tag !== 18'h55 || out_l_data !== 16'h000A || out_r_data !== 16'h000B) begin errors++; $display("FAIL bp_hold[%0d]: got ov=%b tag=%h %h %h want 1 00055 000a 000b", k, out_valid, out_tag, out_l_data, out_r_data); end
        end
        step(1'b1, 18'h66, 1'b1, 16'h000D, 1'b1, 1'b0, r);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", r); end
        checks++; if (out_valid !== 1'b1 || out_tag !== 18'h66 || out_l_data !== 16'h000C || out_r_data !== 16'h000D || count !== 4'd0) begin errors++; $display("FAIL bp_second: got ov=%b tag=%h %h %h count=%0d want 1 00066 000c 000d 0", out_valid, out_tag, out_l_data, out_r_data, count); end
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, r);
    endtask

    task automatic test_flush();
        logic r;
        step(1'b1, 18'h07, 1'b0, 16'h0007, 1'b1, 1'b0, r);
        step(1'b1, 18'h08, 1'b0, 16'h0008, 1'b1, 1'b0, r);
        step(1'b1, 18'h09, 1'b0, 16'h0009, 1'b1, 1'b0, r);
        step(1'b1, 18'h0B, 1'b0, 16'h000B, 1'b1, 1'b0, r);
        step(1'b1, 18'h0B, 1'b1, 16'h00BB, 1'b0, 1'b0, r);
        checks++; if (count !== 4'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_setup: got count=%0d ov=%b want 3 1", count, out_valid); end
        step(1'b1, 18'h0A, 1'b0, 16'h000A, 1'b0, 1'b1, r);
        checks++; if (r !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", r); end
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_count: got %0d empty=%b want 0 1", count, empty); end
        checks++; if (out_valid !== 1'b1 || out_tag !== 18'h0B || out_r_data !== 16'h00BB) begin errors++; $display("FAIL flush_output_kept: got ov=%b tag=%h r=%h want 1 0000b 00bb", out_valid, out_tag, out_r_data); end
        step(1'b1, 18'h0A, 1'b1, 16'h00AA, 1'b1, 1'b0, r);
        checks++; if (count !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_token_dropped: got count=%0d ov=%b want 1 0", count, out_valid); end
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, r);
    endtask

    task automatic test_mr_midstream();
        logic r;
        step(1'b1, 18'h21, 1'b0, 16'h0001, 1'b1, 1'b0, r);
        step(1'b1, 18'h22, 1'b0, 16'h0002, 1'b1, 1'b0, r);
        step(1'b1, 18'h21, 1'b1, 16'h0003, 1'b0, 1'b0, r);
        checks++; if (out_valid !== 1'b1 || count !== 4'd1) begin errors++; $display("FAIL mr_setup: got ov=%b count=%0d want 1 1", out_valid, count); end
        #2;
        mr = 1'b0; in_valid = 1'b1; in_tag = 18'h22; in_lr = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_tag !== '0 || out_l_data !== '0 || out_r_data !== '0) begin errors++; $display("FAIL mr_outputs: got ov=%b tag=%h %h %h want 0 0 0 0", out_valid, out_tag, out_l_data, out_r_data); end
        checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mr_flags: got count=%0d empty=%b full=%b ready=%b want 0 1 0 0", count, empty, full, in_ready); end
        in_valid = 1'b0;
        @(negedge cp);
        mr = 1'b1;
        @(posedge cp);
        #1;
        step(1'b1, 18'h22, 1'b1, 16'h0004, 1'b1, 1'b0, r);
        checks++; if (count !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL mr_entries_gone: got count=%0d ov=%b want 1 0", count, out_valid); end
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, r);
    endtask

    // Reference model: an array of slots filled/emptied by the lowest-index rules, plus the packet register.
    task automatic test_random();
        logic              m_v [DEPTH];
        logic [TAG_W-1:0]  m_t [DEPTH];
        logic              m_l [DEPTH];
        logic [DATA_W-1:0] m_d [DEPTH];
        logic              m_ov;
        logic [TAG_W-1:0]  m_otag;
        logic [DATA_W-1:0] m_ol;
        logic [DATA_W-1:0] m_or;
        logic r;
        logic v, lr, ordy, fl, exp_rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] d;
        int hi, fi, occ;
        logic [CNT_W-1:0]  exp_cnt;
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
        m_ov = 1'b0; m_otag = '0; m_ol = '0; m_or = '0;
        for (int n = 0; n < 600; n++) begin
            v    = ($urandom_range(0, 9) < 8);
            tag  = TAG_W'($urandom_range(0, 5));
            lr   = 1'($urandom_range(0, 1));
            d    = DATA_W'($urandom);
            ordy = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 49) == 0);
            hi = -1; fi = -1; occ = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_v[i]) occ++;
                if (hi < 0 && m_v[i] && m_t[i] == tag && m_l[i] != lr) hi = i;
                if (fi < 0 && !m_v[i]) fi = i;
            end
            exp_rdy = !fl && (!m_ov || ordy) && (hi >= 0 || occ < DEPTH);
            step(v, tag, lr, d, ordy, fl, r);
            if (v) begin
                checks++; if (r !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, r, exp_rdy); end
            end
            if (v && exp_rdy && hi >= 0) begin
                m_ov = 1'b1; m_otag = tag;
                m_ol = lr ? m_d[hi] : d;
                m_or = lr ? d : m_d[hi];
                m_v[hi] = 1'b0;
            end else begin
                if (ordy) m_ov = 1'b0;
                if (v && exp_rdy) begin
                    m_v[fi] = 1'b1; m_t[fi] = tag; m_l[fi] = lr; m_d[fi] = d;
                end
            end
            if (fl) for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
            occ = 0;
            for (int i = 0; i < DEPTH; i++) if (m_v[i]) occ++;
            exp_cnt = CNT_W'(occ);
            checks++; if (count !== exp_cnt || full !== (occ == DEPTH) || empty !== (occ == 0)) begin errors++; $display("FAIL rand_count[%0d]: got count=%0d full=%b empty=%b want %0d", n, count, full, empty, exp_cnt); end
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", n, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (out_tag !== m_otag || out_l_data !== m_ol || out_r_data !== m_or) begin errors++; $display("FAIL rand_packet[%0d]: got %h %h %h want %h %h %h", n, out_tag, out_l_data, out_r_data, m_otag, m_ol, m_or); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pair_fire();
        test_reverse();
        test_same_side();
        test_full();
        test_backpressure();
        test_flush();
        test_mr_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
